// File: rtl/dtc_pkg.sv
// Shared types for the decision-tree class vote block.
// Class width and state encoding used by the top and the vote bank.
package dtc_pkg;

  localparam int CLASS_W     = 3;
  localparam int NUM_CLASSES = 8;

  typedef logic [CLASS_W-1:0] class_t;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    HOLD  = 2'd2
  } vote_state_t;

endpackage

// File: rtl/dtc_vote_bank.sv
// Per-class vote counters: increment by index, clear, and read mux.
// The read port is combinational so the scan can compare every cycle.
module dtc_vote_bank #(
  parameter int NUM_CLASSES = 8,
  parameter int CLASS_W     = 3,
  parameter int CNT_W       = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic [CLASS_W-1:0] inc_idx,
  input  logic               clr,
  input  logic [CLASS_W-1:0] rd_idx,
  output logic [CNT_W-1:0]   rd_cnt
);

  logic [CNT_W-1:0] cnt [NUM_CLASSES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++)
        cnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_CLASSES; i++)
        cnt[i] <= '0;
    end else if (inc) begin
      cnt[inc_idx] <= cnt[inc_idx] + CNT_W'(1);
    end
  end

  assign rd_cnt = cnt[rd_idx];

endmodule

// File: rtl/dtc_class_vote.sv
// Windowed majority vote over classifier decisions.
// Accumulates a window, scans for argmax, then holds the result.
module dtc_class_vote #(
  parameter int CLASS_W     = dtc_pkg::CLASS_W,
  parameter int NUM_CLASSES = dtc_pkg::NUM_CLASSES,
  parameter int WINDOW      = 16,
  parameter int CNT_W       = $clog2(WINDOW + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CLASS_W-1:0] in_class,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLASS_W-1:0] out_class,
  output logic [CNT_W-1:0]   out_count,
  output logic [CNT_W-1:0]   out_total
);

  import dtc_pkg::*;

  localparam int IW = CLASS_W + 1;

  vote_state_t        state;
  logic [CNT_W-1:0]   total;
  logic [CNT_W-1:0]   total_next;
  logic [IW-1:0]      scan_idx;
  logic [CLASS_W-1:0] rd_idx;
  logic [CNT_W-1:0]   rd_cnt;
  logic [CLASS_W-1:0] best_idx;
  logic [CNT_W-1:0]   best_cnt;
  logic               accept;
  logic               close;
  logic               clr;
  logic               scan_done;

  assign in_ready   = (state == ACCUM);
  assign out_valid  = (state == HOLD);
  assign accept     = in_ready && in_valid;
  assign total_next = total + CNT_W'(accept);
  assign close      = in_ready &&
                      ((accept && total_next == CNT_W'(WINDOW)) ||
                       (flush && total_next != '0));
  assign clr        = out_valid && out_ready;
  assign rd_idx     = scan_idx[CLASS_W-1:0];
  assign scan_done  = (scan_idx == IW'(NUM_CLASSES));

  dtc_vote_bank #(
    .NUM_CLASSES(NUM_CLASSES),
    .CLASS_W    (CLASS_W),
    .CNT_W      (CNT_W)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .inc    (accept),
    .inc_idx(in_class),
    .clr    (clr),
    .rd_idx (rd_idx),
    .rd_cnt (rd_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      total     <= '0;
      scan_idx  <= '0;
      best_idx  <= '0;
      best_cnt  <= '0;
      out_class <= '0;
      out_count <= '0;
      out_total <= '0;
    end else begin
      unique case (state)
        ACCUM: begin
          total <= total_next;
          if (close) begin
            state    <= SCAN;
            scan_idx <= '0;
            best_idx <= '0;
            best_cnt <= '0;
          end
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties
          if (scan_done) begin
            state     <= HOLD;
            out_class <= best_idx;
            out_count <= best_cnt;
            out_total <= total;
          end else begin
            scan_idx <= scan_idx + IW'(1);
            if (rd_cnt > best_cnt) begin
              best_idx <= rd_idx;
              best_cnt <= rd_cnt;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= ACCUM;
            total <= '0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_dtc_class_vote.sv
// Directed bench for the windowed class vote block.
// Each task drives one scenario and checks its own results.
module tb_dtc_class_vote;

  import dtc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  class_t     in_class;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  class_t     out_class;
  logic [4:0] out_count;
  logic [4:0] out_total;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dtc_class_vote dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_class (in_class),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .out_count(out_count),
    .out_total(out_total)
  );

  task automatic send(input int cls, input logic fl);
    in_valid = 1'b1;
    in_class = class_t'(cls);
    flush    = fl;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_class = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got ready=%b valid=%b want 1 0",
               in_ready, out_valid);
    end
    checks++;
    if (out_class !== 3'd0 || out_count !== 5'd0 || out_total !== 5'd0) begin
      errors++;
      $display("FAIL reset_out got %0d %0d %0d want 0 0 0",
               out_class, out_count, out_total);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_window();
    int lat;
    for (int i = 0; i < 16; i++) send(i < 10 ? 5 : 2, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_in_ready got %b want 0", in_ready);
    end
    wait_out(lat);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL full_latency got %0d want 9", lat);
    end
    checks++;
    if (out_class !== 3'd5 || out_count !== 5'd10 || out_total !== 5'd16) begin
      errors++;
      $display("FAIL full_result got %0d %0d %0d want 5 10 16",
               out_class, out_count, out_total);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pulse got valid=%b ready=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_tie();
    int lat;
    for (int i = 0; i < 16; i++) send(i < 8 ? 3 : 1, 1'b0);
    wait_out(lat);
    checks++;
    if (out_class !== 3'd1 || out_count !== 5'd8 || out_total !== 5'd16) begin
      errors++;
      $display("FAIL tie_result got %0d %0d %0d want 1 8 16",
               out_class, out_count, out_total);
    end
    tick();
  endtask

  task automatic test_flush();
    int lat;
    int spurious;
    send(6, 1'b0);
    send(6, 1'b0);
    send(4, 1'b1);
    wait_out(lat);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL flush_latency got %0d want 9", lat);
    end
    checks++;
    if (out_class !== 3'd6 || out_count !== 5'd2 || out_total !== 5'd3) begin
      errors++;
      $display("FAIL flush_result got %0d %0d %0d want 6 2 3",
               out_class, out_count, out_total);
    end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    spurious = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious++;
      tick();
    end
    checks++;
    if (spurious !== 0) begin
      errors++;
      $display("FAIL empty_flush got %0d bad cycles want 0", spurious);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(i < 12 ? 4 : 1, 1'b0);
    wait_out(lat);
    checks++;
    if (out_class !== 3'd4 || out_count !== 5'd12 || out_total !== 5'd16) begin
      errors++;
      $display("FAIL bp_result got %0d %0d %0d want 4 12 16",
               out_class, out_count, out_total);
    end
    bad = 0;
    in_valid = 1'b1;
    in_class = 3'd0;
    flush = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_class !== 3'd4 ||
          out_count !== 5'd12 || out_total !== 5'd16) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold got %0d bad cycles want 0", bad);
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got valid=%b ready=%b want 0 1",
               out_valid, in_ready);
    end
    for (int i = 0; i < 16; i++) send(6, 1'b0);
    wait_out(lat);
    checks++;
    if (out_class !== 3'd6 || out_count !== 5'd16 || out_total !== 5'd16) begin
      errors++;
      $display("FAIL bp_next got %0d %0d %0d want 6 16 16",
               out_class, out_count, out_total);
    end
    tick();
  endtask

  task automatic test_reset_scan();
    int lat;
    for (int i = 0; i < 16; i++) send(3, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_scan got valid=%b ready=%b want 0 1",
               out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) send(7, 1'b0);
    wait_out(lat);
    checks++;
    if (lat !== 9 || out_class !== 3'd7 || out_count !== 5'd16 ||
        out_total !== 5'd16) begin
      errors++;
      $display("FAIL rst_next got lat=%0d %0d %0d %0d want 9 7 16 16",
               lat, out_class, out_count, out_total);
    end
    tick();
  endtask

  task automatic test_gapped();
    int lat;
    for (int i = 0; i < 16; i++) begin
      send(0, 1'b0);
      in_class = 3'd5;
      tick();
    end
    wait_out(lat);
    checks++;
    if (out_class !== 3'd0 || out_count !== 5'd16 || out_total !== 5'd16) begin
      errors++;
      $display("FAIL gap_result got %0d %0d %0d want 0 16 16",
               out_class, out_count, out_total);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_window();
    test_tie();
    test_flush();
    test_backpressure();
    test_reset_scan();
    test_gapped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
